// File: rtl/rail_rush_pkg.sv
// Shared Rail Rush types and constants: game states, speed width, lane and obstacle encodings.
package rail_rush_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    RUN       = 3'd2,
    HIT_PAUSE = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  localparam int SPEED_W = 4;
  localparam int CD_W    = 8;

  localparam int         LANE_COUNT  = 3;
  localparam logic [1:0] LANE_LEFT   = 2'd0;
  localparam logic [1:0] LANE_CENTER = 2'd1;
  localparam logic [1:0] LANE_RIGHT  = 2'd2;

  typedef enum logic [1:0] {
    OBS_NONE    = 2'd0,
    OBS_BARRIER = 2'd1,
    OBS_TRAIN   = 2'd2,
    OBS_COIN    = 2'd3
  } obstacle_type_t;

  // Next speed step, clamped at the supplied ceiling.
  function automatic logic [SPEED_W-1:0] speed_step(input logic [SPEED_W-1:0] cur,
                                                    input logic [SPEED_W-1:0] ceiling);
    if (cur >= ceiling) begin
      return ceiling;
    end else begin
      return cur + {{(SPEED_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/game_flow_controller_frame_down_counter.sv
// Frame-paced down counter shared by the COUNTDOWN and HIT_PAUSE phases.
// Counts down on each tick, stops at zero; done flags the last frame (count == 1).
module frame_down_counter
  import rail_rush_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic [CD_W-1:0] load_value,
  input  logic            clear,
  input  logic            tick,
  output logic [CD_W-1:0] count,
  output logic            done
);

  logic [CD_W-1:0] count_r;

  // Load has priority over clear, clear over the per-frame decrement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {CD_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (clear) begin
      count_r <= {CD_W{1'b0}};
    end else if (tick && (count_r != {CD_W{1'b0}})) begin
      count_r <= count_r - {{(CD_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign done  = (count_r == {{(CD_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/game_flow_controller.sv
// Rail Rush gameplay sequencer: IDLE -> COUNTDOWN -> RUN -> HIT_PAUSE / GAME_OVER,
// with lives, saturating score, speed ramp and high score tracking.
module game_flow_controller
  import rail_rush_pkg::*;
#(
  parameter int unsigned START_LIVES      = 3,
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned PAUSE_FRAMES     = 60,
  parameter int unsigned SPEED_INIT       = 2,
  parameter int unsigned SPEED_MAX        = 12,
  parameter int unsigned RAMP_FRAMES      = 600,
  parameter int unsigned SCORE_W          = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_done,
  input  logic               start_btn,
  input  logic               hit,
  output logic               game_active,
  output logic [SPEED_W-1:0] speed,
  output logic               obs_flush,
  output logic [2:0]         state,
  output logic [2:0]         lives,
  output logic [CD_W-1:0]    countdown,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score
);

  localparam int unsigned RAMP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam logic [RAMP_W-1:0]  RAMP_LAST   = RAMP_W'(RAMP_FRAMES - 1);
  localparam logic [SPEED_W-1:0] SPEED_CEIL  = SPEED_W'(SPEED_MAX);
  localparam logic [SPEED_W-1:0] SPEED_START = SPEED_W'(SPEED_INIT);
  localparam logic [2:0]         LIVES_START = 3'(START_LIVES);

  game_state_t        state_r;
  logic               game_active_r;
  logic [SPEED_W-1:0] speed_r;
  logic               obs_flush_r;
  logic [2:0]         lives_r;
  logic [SCORE_W-1:0] score_r;
  logic [SCORE_W-1:0] high_score_r;
  logic [RAMP_W-1:0]  ramp_r;
  logic               start_q_r;
  logic               hs_pending_r;

  logic               start_rise_s;
  logic [SCORE_W:0]   score_sum_s;
  logic [SCORE_W-1:0] score_next_s;
  logic               cnt_load_s;
  logic [CD_W-1:0]    cnt_value_s;
  logic               cnt_clear_s;
  logic               cnt_tick_s;
  logic [CD_W-1:0]    cnt_count_s;
  logic               cnt_done_s;

  // Start edge detect and saturating score increment.
  always_comb begin
    start_rise_s = start_btn & ~start_q_r;
    score_sum_s  = {1'b0, score_r} + {{(SCORE_W+1-SPEED_W){1'b0}}, speed_r};
    if (score_sum_s[SCORE_W]) begin
      score_next_s = {SCORE_W{1'b1}};
    end else begin
      score_next_s = score_sum_s[SCORE_W-1:0];
    end
  end

  // Counter control: load on game start and non-fatal hit, tick only in timed phases.
  always_comb begin
    cnt_load_s  = 1'b0;
    cnt_value_s = {CD_W{1'b0}};
    cnt_clear_s = 1'b0;
    cnt_tick_s  = 1'b0;
    case (state_r)
      IDLE, GAME_OVER: begin
        if (start_rise_s) begin
          cnt_load_s  = 1'b1;
          cnt_value_s = CD_W'(COUNTDOWN_FRAMES);
        end else begin
          cnt_load_s  = 1'b0;
        end
      end
      COUNTDOWN, HIT_PAUSE: begin
        cnt_tick_s = frame_done;
      end
      RUN: begin
        if (frame_done && hit && (lives_r != 3'd1)) begin
          cnt_load_s  = 1'b1;
          cnt_value_s = CD_W'(PAUSE_FRAMES);
        end else begin
          cnt_load_s  = 1'b0;
        end
      end
      default: begin
        cnt_clear_s = 1'b1;
      end
    endcase
  end

  frame_down_counter u_frame_down_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load_s),
    .load_value (cnt_value_s),
    .clear      (cnt_clear_s),
    .tick       (cnt_tick_s),
    .count      (cnt_count_s),
    .done       (cnt_done_s)
  );

  // Game flow FSM with lives, score, speed ramp and high score.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      game_active_r <= 1'b0;
      speed_r       <= {SPEED_W{1'b0}};
      obs_flush_r   <= 1'b0;
      lives_r       <= 3'd0;
      score_r       <= {SCORE_W{1'b0}};
      high_score_r  <= {SCORE_W{1'b0}};
      ramp_r        <= {RAMP_W{1'b0}};
      start_q_r     <= 1'b0;
      hs_pending_r  <= 1'b0;
    end else begin
      start_q_r   <= start_btn;
      obs_flush_r <= 1'b0;
      if (hs_pending_r) begin
        hs_pending_r <= 1'b0;
        if (score_r > high_score_r) begin
          high_score_r <= score_r;
        end
      end
      case (state_r)
        IDLE, GAME_OVER: begin
          game_active_r <= 1'b0;
          if (start_rise_s) begin
            state_r     <= COUNTDOWN;
            lives_r     <= LIVES_START;
            score_r     <= {SCORE_W{1'b0}};
            speed_r     <= SPEED_START;
            ramp_r      <= {RAMP_W{1'b0}};
            obs_flush_r <= 1'b1;
          end
        end
        COUNTDOWN: begin
          game_active_r <= 1'b0;
          if (frame_done && cnt_done_s) begin
            state_r       <= RUN;
            game_active_r <= 1'b1;
          end
        end
        RUN: begin
          if (frame_done && hit) begin
            game_active_r <= 1'b0;
            lives_r       <= lives_r - 3'd1;
            if (lives_r == 3'd1) begin
              state_r      <= GAME_OVER;
              speed_r      <= {SPEED_W{1'b0}};
              hs_pending_r <= 1'b1;
            end else begin
              state_r <= HIT_PAUSE;
            end
          end else begin
            game_active_r <= 1'b1;
            if (frame_done) begin
              score_r <= score_next_s;
              if (ramp_r == RAMP_LAST) begin
                ramp_r  <= {RAMP_W{1'b0}};
                speed_r <= speed_step(speed_r, SPEED_CEIL);
              end else begin
                ramp_r <= ramp_r + {{(RAMP_W-1){1'b0}}, 1'b1};
              end
            end
          end
        end
        HIT_PAUSE: begin
          // Flush lands while game_active is still low; movement resumes a cycle later.
          game_active_r <= 1'b0;
          if (frame_done && cnt_done_s) begin
            state_r     <= RUN;
            obs_flush_r <= 1'b1;
          end
        end
        default: begin
          state_r       <= IDLE;
          game_active_r <= 1'b0;
          speed_r       <= {SPEED_W{1'b0}};
          lives_r       <= 3'd0;
        end
      endcase
    end
  end

  assign game_active = game_active_r;
  assign speed       = speed_r;
  assign obs_flush   = obs_flush_r;
  assign state       = state_r;
  assign lives       = lives_r;
  assign countdown   = cnt_count_s;
  assign score       = score_r;
  assign high_score  = high_score_r;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: per-cycle comparison against a frame-level
// game model, plus hand-computed literal checks and a 4-bit score saturation instance.
module tb_game_flow_controller;

  localparam int START_LIVES = 3;
  localparam int CDF         = 180;
  localparam int PF          = 60;
  localparam int SPI         = 2;
  localparam int SPM         = 12;
  localparam int RF          = 600;
  localparam int SW          = 16;
  localparam int SMAX        = 65535;

  localparam int S_IDLE = 0, S_CD = 1, S_RUN = 2, S_HP = 3, S_OVER = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_done = 1'b0, start_btn = 1'b0, hit = 1'b0;
  logic        game_active, obs_flush;
  logic [3:0]  speed;
  logic [2:0]  state, lives;
  logic [7:0]  countdown;
  logic [15:0] score, high_score;

  logic        s_fd = 1'b0, s_start = 1'b0, s_hit = 1'b0;
  logic        s_active, s_flush;
  logic [3:0]  s_speed;
  logic [2:0]  s_state, s_lives;
  logic [7:0]  s_cd;
  logic [3:0]  s_score, s_hs;

  int checks = 0;
  int failures = 0;
  logic hold_start = 1'b0;

  int m_state, m_active, m_speed, m_flush, m_lives, m_cd, m_score, m_hs, m_ramp;
  int m_start_q, m_hs_pend;

  always #5 clock = ~clock;

  game_flow_controller u_dut (
    .clock(clock), .reset(reset), .frame_done(frame_done), .start_btn(start_btn), .hit(hit),
    .game_active(game_active), .speed(speed), .obs_flush(obs_flush), .state(state),
    .lives(lives), .countdown(countdown), .score(score), .high_score(high_score)
  );

  game_flow_controller #(.COUNTDOWN_FRAMES(2), .PAUSE_FRAMES(2), .SPEED_INIT(5), .SCORE_W(4)) u_small (
    .clock(clock), .reset(reset), .frame_done(s_fd), .start_btn(s_start), .hit(s_hit),
    .game_active(s_active), .speed(s_speed), .obs_flush(s_flush), .state(s_state),
    .lives(s_lives), .countdown(s_cd), .score(s_score), .high_score(s_hs)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_active = 0; m_speed = 0; m_flush = 0; m_lives = 0; m_cd = 0;
    m_score = 0; m_hs = 0; m_ramp = 0; m_start_q = 0; m_hs_pend = 0;
  endtask

  // Frame-level game rules applied once per clock.
  task automatic model_step(input logic fd, input logic h, input logic st);
    int rise;
    rise = (st && m_start_q == 0) ? 1 : 0;
    m_start_q = st ? 1 : 0;
    m_flush = 0;
    if (m_hs_pend != 0) begin
      if (m_score > m_hs) m_hs = m_score;
      m_hs_pend = 0;
    end
    case (m_state)
      S_IDLE, S_OVER: begin
        if (rise != 0) begin
          m_state = S_CD; m_lives = START_LIVES; m_score = 0; m_speed = SPI;
          m_ramp = 0; m_cd = CDF; m_flush = 1;
        end
      end
      S_CD: begin
        if (fd) begin
          m_cd--;
          if (m_cd == 0) begin m_state = S_RUN; m_active = 1; end
        end
      end
      S_RUN: begin
        if (fd && h) begin
          m_active = 0;
          m_lives--;
          if (m_lives == 0) begin m_state = S_OVER; m_speed = 0; m_hs_pend = 1; end
          else begin m_state = S_HP; m_cd = PF; end
        end else begin
          m_active = 1;
          if (fd) begin
            m_score = (m_score + m_speed > SMAX) ? SMAX : m_score + m_speed;
            m_ramp++;
            if (m_ramp == RF) begin
              m_ramp = 0;
              if (m_speed < SPM) m_speed++;
            end
          end
        end
      end
      S_HP: begin
        if (fd) begin
          m_cd--;
          if (m_cd == 0) begin m_state = S_RUN; m_flush = 1; end
        end
      end
      default: m_state = S_IDLE;
    endcase
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else model_step(frame_done, hit, start_btn);
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    check("state", state, m_state);
    check("game_active", game_active, m_active);
    check("speed", speed, m_speed);
    check("obs_flush", obs_flush, m_flush);
    check("lives", lives, m_lives);
    check("countdown", countdown, m_cd);
    check("score", score, m_score);
    check("high_score", high_score, m_hs);
    check("flush_with_active", obs_flush & game_active, 0);
  end

  task automatic cyc(input logic fd, input logic h, input logic st);
    @(negedge clock);
    frame_done = fd; hit = h; start_btn = st;
    @(posedge clock);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, hold_start);
      cyc(1'b0, 1'b0, hold_start);
    end
  endtask

  task automatic cyc2(input logic fd, input logic st);
    @(negedge clock);
    s_fd = fd; s_start = st;
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_state", state, 0);
    check("rst_speed", speed, 0);
    check("rst_lives", lives, 0);
    check("rst_score", score, 0);
    reset = 1'b0;

    // Game 1: start, countdown, run
    cyc(1'b0, 1'b0, 1'b1);
    check("start_flush", obs_flush, 1);
    check("start_state", state, S_CD);
    check("start_countdown", countdown, 180);
    check("start_lives", lives, 3);
    cyc(1'b0, 1'b0, 1'b1);
    check("flush_one_cycle", obs_flush, 0);
    cyc(1'b0, 1'b0, 1'b0);
    frames(180);
    check("run_state", state, S_RUN);
    check("run_active", game_active, 1);
    check("run_speed", speed, 2);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("start_in_run", state, S_RUN);
    frames(600);
    check("ramp1_speed", speed, 3);
    check("ramp1_score", score, 1200);

    // Hits and pause
    cyc(1'b0, 1'b1, 1'b0);
    check("hit_no_frame", lives, 3);
    cyc(1'b1, 1'b1, 1'b0);
    check("hit1_lives", lives, 2);
    check("hit1_state", state, S_HP);
    check("hit1_active", game_active, 0);
    check("hit1_countdown", countdown, 60);
    frames(59);
    check("pause_cd_last", countdown, 1);
    cyc(1'b1, 1'b0, 1'b0);
    check("resume_state", state, S_RUN);
    check("resume_flush", obs_flush, 1);
    check("resume_active_low", game_active, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("resume_active", game_active, 1);
    frames(6000);
    check("speed_saturated", speed, 12);
    check("long_score", score, 46200);

    cyc(1'b1, 1'b1, 1'b0);
    check("hit2_lives", lives, 1);
    frames(60);
    cyc(1'b1, 1'b1, 1'b0);
    check("over_state", state, S_OVER);
    check("over_lives", lives, 0);
    check("over_speed", speed, 0);
    check("hs_not_yet", high_score, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("hs_game1", high_score, 46200);

    // Game 2 with start held high throughout, lower score
    hold_start = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    check("g2_state", state, S_CD);
    frames(180);
    frames(10);
    cyc(1'b1, 1'b1, 1'b1);
    frames(60);
    cyc(1'b1, 1'b1, 1'b1);
    frames(60);
    cyc(1'b1, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    check("held_no_restart", state, S_OVER);
    check("g2_score", score, 20);
    check("hs_kept", high_score, 46200);

    // Game 3, reset mid pause
    hold_start = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check("g3_state", state, S_CD);
    cyc(1'b0, 1'b0, 1'b0);
    frames(180);
    frames(3);
    cyc(1'b1, 1'b1, 1'b0);
    frames(5);
    check("g3_pause", state, S_HP);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_active", game_active, 0);
    check("arst_speed", speed, 0);
    check("arst_flush", obs_flush, 0);
    check("arst_lives", lives, 0);
    check("arst_cd", countdown, 0);
    check("arst_score", score, 0);
    check("arst_hs", high_score, 0);
    @(negedge clock);
    reset = 1'b0;

    // Small instance: 4-bit score saturation
    cyc2(1'b0, 1'b1);
    check("sm_state", s_state, S_CD);
    check("sm_cd", s_cd, 2);
    cyc2(1'b1, 1'b0);
    cyc2(1'b1, 1'b0);
    check("sm_run", s_state, S_RUN);
    cyc2(1'b1, 1'b0);
    check("sm_score5", s_score, 5);
    cyc2(1'b1, 1'b0);
    check("sm_score10", s_score, 10);
    cyc2(1'b1, 1'b0);
    check("sm_score15", s_score, 15);
    cyc2(1'b1, 1'b0);
    check("sm_score_sat", s_score, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
